busca_instrucao: RTL and testbench

Instruction-fetch stage that sits directly upstream of the control unit and datapath. It owns the PC register and fetches each instruction from instruction memory over a req/ack handshake. It holds the fetched word and its decoded fields (opcode, f3, f7) for the control unit until the downstream stage accepts it. On acceptance it selects the next PC from that cycle's branch/jump resolution (PCSrc, Tipo_Branch, ALU flags).

---
 rtl/busca_instrucao.sv | 136 +++++++++++++
 tb/tb_busca_instrucao.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/busca_instrucao.sv
// Instruction-fetch stage: owns the PC, fetches one word per req/ack handshake,
// holds it (with decoded opcode/f3/f7) until the downstream stage accepts it,
// then picks the next PC from the branch/jump resolution presented on accept.
module busca_instrucao #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h00000000,
    parameter logic [XLEN-1:0] NOP_WORD = 32'h00000013
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_data,
    input  logic            instr_ready,
    input  logic            PCSrc,
    input  logic [2:0]      Tipo_Branch,
    input  logic            zero,
    input  logic            neg,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] instr,
    output logic [6:0]      opcode,
    output logic [2:0]      f3,
    output logic [6:0]      f7,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            instr_valid,
    output logic [31:0]     instret
);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            valid_q, valid_d;
    logic [31:0]     instret_q, instret_d;

    logic            decision;
    logic            take;
    logic [XLEN-1:0] target_aligned;
    logic [XLEN-1:0] seq_pc;

    // Target alignment always drops the two low bits, so they are never read.
    logic unused_target_bits;
    assign unused_target_bits = ^branch_target[1:0];

    assign seq_pc         = pc_q + PC_STEP;
    assign target_aligned = {branch_target[XLEN-1:2], 2'b00};

    // Branch condition by branch type; 0 and 7 never redirect.
    always_comb begin
        decision = 1'b0;
        case (Tipo_Branch)
            3'd1:    decision = zero;
            3'd2:    decision = ~zero;
            3'd3:    decision = neg;
            3'd4:    decision = ~neg;
            3'd5:    decision = neg;
            3'd6:    decision = 1'b1;
            default: decision = 1'b0;
        endcase
    end

    // PCSrc gates the decision so non-branch ops that alias a branch type
    // (e.g. R-type with f3=0 -> type 1) cannot redirect.
    assign take = PCSrc & decision;

    // Next-state logic: fetch until ack, then hold until accepted.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        instret_d = instret_q;
        case (state_q)
            S_RESET: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_data;
                    valid_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (instr_ready) begin
                    pc_d      = take ? target_aligned : seq_pc;
                    instret_d = instret_q + 32'd1;
                    instr_d   = NOP_WORD;
                    valid_d   = 1'b0;
                    state_d   = S_FETCH;
                end
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    // State registers with synchronous reset; reset wins over any pending ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_RESET;
            pc_q      <= RESET_PC;
            instr_q   <= NOP_WORD;
            valid_q   <= 1'b0;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            instret_q <= instret_d;
        end
    end

    assign imem_req    = (state_q == S_FETCH);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[6:0];
    assign f3          = instr_q[14:12];
    assign f7          = instr_q[31:25];
    assign pc          = pc_q;
    assign pc_plus4    = seq_pc;
    assign instr_valid = valid_q;
    assign instret     = instret_q;

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed bench for busca_instrucao: a table of fetch/accept records plus
// hand-written sequences for wait states, stalls and reset during fetch.
module tb_busca_instrucao;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        instr_ready;
    logic        PCSrc;
    logic [2:0]  Tipo_Branch;
    logic        zero;
    logic        neg;
    logic [31:0] branch_target;

    logic        imem_req,  imem_req2;
    logic [31:0] imem_addr, imem_addr2;
    logic [31:0] instr,     instr2;
    logic [6:0]  opcode,    opcode2;
    logic [2:0]  f3,        f3_2;
    logic [6:0]  f7,        f7_2;
    logic [31:0] pc,        pc2;
    logic [31:0] pc_plus4,  pc_plus4_2;
    logic        instr_valid, instr_valid2;
    logic [31:0] instret,   instret2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    busca_instrucao dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .instr_ready(instr_ready), .PCSrc(PCSrc), .Tipo_Branch(Tipo_Branch),
        .zero(zero), .neg(neg), .branch_target(branch_target),
        .instr(instr), .opcode(opcode), .f3(f3), .f7(f7),
        .pc(pc), .pc_plus4(pc_plus4), .instr_valid(instr_valid), .instret(instret)
    );

    // Second instance starting at the top of the address space for wrap checks.
    busca_instrucao #(.RESET_PC(32'hFFFFFFFC)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .instr_ready(instr_ready), .PCSrc(PCSrc), .Tipo_Branch(Tipo_Branch),
        .zero(zero), .neg(neg), .branch_target(branch_target),
        .instr(instr2), .opcode(opcode2), .f3(f3_2), .f7(f7_2),
        .pc(pc2), .pc_plus4(pc_plus4_2), .instr_valid(instr_valid2), .instret(instret2)
    );

    typedef struct {
        logic [31:0] word;
        logic        pcsrc;
        logic [2:0]  tipo;
        logic        z;
        logic        n;
        logic [31:0] tgt;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end else begin
            $display("ok   %s: %08h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_branch();
        PCSrc = 1'b0; Tipo_Branch = 3'd0; zero = 1'b0; neg = 1'b0;
        branch_target = 32'h0;
    endtask

    // Holds reset for two edges; on return the DUT is in RESET with rst low.
    task automatic do_reset();
        rst = 1'b1; imem_ack = 1'b0; imem_data = 32'h0; instr_ready = 1'b0;
        clear_branch();
        tick(); tick();
        rst = 1'b0;
    endtask

    // Waits (bounded) for a request, then returns word with a single-cycle ack.
    task automatic do_fetch(input logic [31:0] word, input logic [31:0] exp_addr);
        int k;
        k = 0;
        while (imem_req !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk("fetch_req", {31'd0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, exp_addr);
        imem_ack = 1'b1; imem_data = word;
        tick();
        imem_ack = 1'b0; imem_data = 32'hDEADBEEF;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //             word          src  tipo  z     n     tgt            exp_pc
        vecs[0]  = '{32'h00500093, 1'b0, 3'd0, 1'b0, 1'b0, 32'h00000000, 32'h00000004};
        vecs[1]  = '{32'h00000463, 1'b1, 3'd1, 1'b1, 1'b0, 32'h00000040, 32'h00000040};
        vecs[2]  = '{32'h00000463, 1'b1, 3'd1, 1'b0, 1'b0, 32'h00000100, 32'h00000044};
        vecs[3]  = '{32'h002081B3, 1'b0, 3'd1, 1'b1, 1'b0, 32'h00000200, 32'h00000048};
        vecs[4]  = '{32'h00001463, 1'b1, 3'd2, 1'b0, 1'b0, 32'h00000080, 32'h00000080};
        vecs[5]  = '{32'h00001463, 1'b1, 3'd2, 1'b1, 1'b0, 32'h00000300, 32'h00000084};
        vecs[6]  = '{32'h00004463, 1'b1, 3'd3, 1'b0, 1'b1, 32'h00000010, 32'h00000010};
        vecs[7]  = '{32'h00005463, 1'b1, 3'd4, 1'b0, 1'b1, 32'h00000400, 32'h00000014};
        vecs[8]  = '{32'h00005463, 1'b1, 3'd4, 1'b0, 1'b0, 32'h00000030, 32'h00000030};
        vecs[9]  = '{32'h00006463, 1'b1, 3'd5, 1'b0, 1'b1, 32'h00000052, 32'h00000050};
        vecs[10] = '{32'h0000006F, 1'b1, 3'd6, 1'b0, 1'b0, 32'h00000103, 32'h00000100};
        vecs[11] = '{32'hFE000EE3, 1'b1, 3'd7, 1'b1, 1'b1, 32'h00000200, 32'h00000104};
        vecs[12] = '{32'h40208033, 1'b1, 3'd0, 1'b1, 1'b1, 32'h00000300, 32'h00000108};

        // ---- reset state ----
        do_reset();
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_instr", instr, NOP);
        chk("rst_opcode", {25'd0, opcode}, 32'd19);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instret", instret, 32'd0);
        chk("rst_pc_wrap", pc2, 32'hFFFFFFFC);

        // ---- table: zero-wait memory, accept immediately ----
        for (int i = 0; i < 13; i++) begin
            logic [31:0] w;
            logic [31:0] old_pc;
            w = vecs[i].word;
            if (i == 0) begin
                // instr_valid must appear exactly two edges after reset release
                tick();
                chk("first_req", {31'd0, imem_req}, 32'd1);
                imem_ack = 1'b1; imem_data = w;
                tick();
                imem_ack = 1'b0;
            end else begin
                do_fetch(w, vecs[i-1].exp_pc);
            end
            old_pc = (i == 0) ? 32'h0 : vecs[i-1].exp_pc;
            chk($sformatf("v%0d_valid", i), {31'd0, instr_valid}, 32'd1);
            chk($sformatf("v%0d_instr", i), instr, w);
            chk($sformatf("v%0d_opcode", i), {25'd0, opcode}, {25'd0, w[6:0]});
            chk($sformatf("v%0d_f3f7", i), {22'd0, f7, f3}, {22'd0, w[31:25], w[14:12]});
            chk($sformatf("v%0d_pc_plus4", i), pc_plus4, old_pc + 32'd4);
            instr_ready = 1'b1;
            PCSrc = vecs[i].pcsrc; Tipo_Branch = vecs[i].tipo;
            zero = vecs[i].z; neg = vecs[i].n; branch_target = vecs[i].tgt;
            tick();
            instr_ready = 1'b0;
            clear_branch();
            chk($sformatf("v%0d_next_pc", i), pc, vecs[i].exp_pc);
            chk($sformatf("v%0d_instret", i), instret, 32'(i + 1));
            chk($sformatf("v%0d_valid_drop", i), {31'd0, instr_valid}, 32'd0);
            if (i == 0) chk("wrap_pc", pc2, 32'h00000000);
        end

        // ---- wait states and stall ----
        do_reset();
        tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("wait%0d_req", k), {31'd0, imem_req}, 32'd1);
            chk($sformatf("wait%0d_addr", k), imem_addr, 32'h0);
            tick();
        end
        imem_ack = 1'b1; imem_data = 32'h00A00113;
        tick();
        imem_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("stall%0d_instr", k), instr, 32'h00A00113);
            chk($sformatf("stall%0d_pc", k), pc, 32'h0);
            chk($sformatf("stall%0d_req", k), {31'd0, imem_req}, 32'd0);
            // ack and branch inputs outside their window must be ignored
            imem_ack = 1'b1; imem_data = 32'h11111111;
            PCSrc = 1'b1; Tipo_Branch = 3'd6; branch_target = 32'h00000800;
            tick();
            imem_ack = 1'b0;
            clear_branch();
        end
        chk("stall_instr_end", instr, 32'h00A00113);
        chk("stall_instret", instret, 32'd0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("stall_accept_pc", pc, 32'h4);
        chk("stall_accept_instret", instret, 32'd1);

        // ---- reset in FETCH with ack on the same edge ----
        do_fetch(32'h12345093, 32'h4);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
        rst = 1'b1; imem_ack = 1'b1; imem_data = 32'hCAFEF00D;
        tick();
        rst = 1'b0;
        // ack kept high into the first cycle after reset: still ignored
        chk("rstf_valid", {31'd0, instr_valid}, 32'd0);
        chk("rstf_instr", instr, NOP);
        chk("rstf_pc", pc, 32'h0);
        chk("rstf_req", {31'd0, imem_req}, 32'd0);
        chk("rstf_instret", instret, 32'd0);
        tick();
        imem_ack = 1'b0;
        chk("rstf_ignored_valid", {31'd0, instr_valid}, 32'd0);
        chk("rstf_refetch_req", {31'd0, imem_req}, 32'd1);
        chk("rstf_refetch_addr", imem_addr, 32'h0);
        do_fetch(32'h00300193, 32'h0);
        chk("rstf_fresh_instr", instr, 32'h00300193);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
